// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder
package sha256_pkg;
    typedef enum logic [1:0] {FILL, PAD, EMIT} PadState;
    typedef logic [15:0][31:0] ChunkWords;
    localparam logic [31:0] PAD_MARKER = 32'h80000000;
    localparam int LEN_WORD_HI = 14;
    localparam int LEN_WORD_LO = 15;
endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: keeps the first n bytes of a word, places 0x80 at byte n and zeroes the tail
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  n,
    output logic [31:0] padded
);
    // n of 4 or more leaves the word untouched, so the marker belongs to the next word
    always_comb begin
        padded = n == 3'd0 ? PAD_MARKER :
                 n == 3'd1 ? {word[31:24], 24'h800000} :
                 n == 3'd2 ? {word[31:16], 16'h8000} :
                 n == 3'd3 ? {word[31:8], 8'h80} : word;
    end
endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 padding of a 32-bit word stream into 512-bit chunks; SHA256_PADDER_DBUF_EN adds a second fill buffer
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_vld,
    output logic              msg_rdy,
    input  logic [31:0]       msg_data,
    input  logic [2:0]        msg_bytes,
    input  logic              msg_last,
    output logic              chunk_vld,
    input  logic              chunk_rdy,
    output logic [15:0][31:0] chunk_data,
    output logic              chunk_last
);
    PadState          st, st_n;
    ChunkWords        bufs [2];
    ChunkWords        bufs_n [2];
    ChunkWords        pc;
    logic [3:0]       idx, idx_n, k, k_n;
    logic [2:0]       n, n_n, nb;
    logic [4:0]       p;
    logic [31:0]      pw;
    logic [LEN_W-1:0] cnt, cnt_n, lenr, lenr_n, bitlen;
    logic             last_r, last_n, pend, pend_n, spill, spill_n;
    logic             wb, wb_n, eb, eb_n, acc, hs;
`ifdef SHA256_PADDER_DBUF_EN
    logic             ffull, ffull_n, flast, flast_n, ff, fl;
    assign msg_rdy = !rst && (st == FILL || (st == EMIT && !ffull && !flast));
`else
    assign msg_rdy = !rst && st == FILL;
`endif
    assign acc        = msg_vld && msg_rdy;
    assign hs         = chunk_vld && chunk_rdy;
    assign nb         = (msg_last && msg_bytes < 3'd4) ? msg_bytes : 3'd4;
    assign bitlen     = cnt << 3;
    assign chunk_vld  = st == EMIT;
    assign chunk_last = last_r;
    assign chunk_data = bufs[eb];

    sha256_pad_word u_pad_word (
        .word   (bufs[wb][k]),
        .n      (n),
        .padded (pw)
    );

    // padded image of the fill buffer: data, marker, zero fill and, when it fits, the bit length
    always_comb begin
        p = {1'b0, k} + (n == 3'd4 ? 5'd2 : 5'd1);
        for (int i = 0; i < 16; i++)
            pc[i] = i < int'(k) ? bufs[wb][i] :
                    i == int'(k) ? pw :
                    (n == 3'd4 && i == int'(k) + 1) ? PAD_MARKER : 32'h0;
        if (p <= 5'd14) begin
            pc[LEN_WORD_HI] = bitlen[63:32];
            pc[LEN_WORD_LO] = bitlen[31:0];
        end
    end

    // next state, buffer writes and chunk bookkeeping
    always_comb begin
        st_n = st;
        bufs_n = bufs;
        idx_n = idx;
        cnt_n = cnt;
        lenr_n = lenr;
        k_n = k;
        n_n = n;
        last_n = last_r;
        pend_n = pend;
        spill_n = spill;
        wb_n = wb;
        eb_n = eb;
`ifdef SHA256_PADDER_DBUF_EN
        ffull_n = ffull;
        flast_n = flast;
        fl = flast || (acc && msg_last);
        ff = ffull || (acc && !msg_last && idx == 4'd15);
`endif
        if (acc) begin
            bufs_n[wb][idx] = msg_data;
            idx_n = idx + 4'd1;
            cnt_n = cnt + LEN_W'(nb);
            k_n = msg_last ? idx : k;
            n_n = msg_last ? nb : n;
        end
        case (st)
            FILL: begin
                st_n = (acc && msg_last) ? PAD : (acc && idx == 4'd15) ? EMIT : FILL;
`ifdef SHA256_PADDER_DBUF_EN
                if (acc && !msg_last && idx == 4'd15) begin
                    eb_n = wb;
                    wb_n = !wb;
                end
`endif
            end
            PAD: begin
                bufs_n[wb] = pc;
                last_n = p <= 5'd14;
                pend_n = p > 5'd14;
                spill_n = n == 3'd4 && k == 4'd15;
                lenr_n = bitlen;
                st_n = EMIT;
`ifdef SHA256_PADDER_DBUF_EN
                eb_n = wb;
                wb_n = !wb;
                idx_n = '0;
                cnt_n = '0;
`endif
            end
            EMIT: begin
`ifdef SHA256_PADDER_DBUF_EN
                ffull_n = ff;
                flast_n = fl;
`endif
                if (hs && pend) begin
                    bufs_n[eb] = '0;
                    bufs_n[eb][0] = spill ? PAD_MARKER : 32'h0;
                    bufs_n[eb][LEN_WORD_HI] = lenr[63:32];
                    bufs_n[eb][LEN_WORD_LO] = lenr[31:0];
                    last_n = 1'b1;
                    pend_n = 1'b0;
                end else if (hs) begin
                    last_n = 1'b0;
`ifdef SHA256_PADDER_DBUF_EN
                    if (ff) begin
                        eb_n = wb;
                        wb_n = !wb;
                        ffull_n = 1'b0;
                    end else if (fl) begin
                        st_n = PAD;
                        flast_n = 1'b0;
                    end else begin
                        st_n = FILL;
                    end
`else
                    st_n = FILL;
                    idx_n = '0;
                    cnt_n = last_r ? '0 : cnt;
`endif
                end
            end
            default: st_n = FILL;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= FILL;
            bufs <= '{default: '0};
            idx <= '0;
            cnt <= '0;
            lenr <= '0;
            k <= '0;
            n <= '0;
            last_r <= 1'b0;
            pend <= 1'b0;
            spill <= 1'b0;
            wb <= 1'b0;
            eb <= 1'b0;
`ifdef SHA256_PADDER_DBUF_EN
            ffull <= 1'b0;
            flast <= 1'b0;
`endif
        end else begin
            st <= st_n;
            bufs <= bufs_n;
            idx <= idx_n;
            cnt <= cnt_n;
            lenr <= lenr_n;
            k <= k_n;
            n <= n_n;
            last_r <= last_n;
            pend <= pend_n;
            spill <= spill_n;
            wb <= wb_n;
            eb <= eb_n;
`ifdef SHA256_PADDER_DBUF_EN
            ffull <= ffull_n;
            flast <= flast_n;
`endif
        end
    end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: random and directed messages checked against a byte-level FIPS 180-4 padding model
module tb_sha256_padder;
    typedef struct {
        logic [15:0][31:0] d;
        logic              l;
    } chunk_t;
    typedef logic [7:0] bq_t[$];

    logic              clk, rst, msg_vld, msg_rdy, msg_last, chunk_vld, chunk_rdy, chunk_last;
    logic [31:0]       msg_data;
    logic [2:0]        msg_bytes;
    logic [15:0][31:0] chunk_data, pd, lit, snap;
    logic              pl;
    chunk_t            expq[$], got[$], mc, me;
    int                errors = 0, checks = 0;
    bit                rand_rdy = 0, gap_en = 0, prev_stall = 0;

    sha256_padder dut (
        .clk        (clk),
        .rst        (rst),
        .msg_vld    (msg_vld),
        .msg_rdy    (msg_rdy),
        .msg_data   (msg_data),
        .msg_bytes  (msg_bytes),
        .msg_last   (msg_last),
        .chunk_vld  (chunk_vld),
        .chunk_rdy  (chunk_rdy),
        .chunk_data (chunk_data),
        .chunk_last (chunk_last)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // random consumer backpressure during the random phase
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) chunk_rdy = $urandom_range(3) != 0;
    end

    task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endtask

    // byte-level padding: append 0x80, zero to 56 mod 64, then the 64-bit big-endian bit length
    task automatic model(input bq_t m);
        bq_t p;
        logic [63:0] bl;
        chunk_t c;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int b = 7; b >= 0; b--) p.push_back(bl[8*b +: 8]);
        for (int ci = 0; ci < p.size() / 64; ci++) begin
            for (int w = 0; w < 16; w++)
                c.d[w] = {p[ci*64+4*w], p[ci*64+4*w+1], p[ci*64+4*w+2], p[ci*64+4*w+3]};
            c.l = (ci == p.size() / 64 - 1);
            expq.push_back(c);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [2:0] b, input logic l);
        int t = 0;
        msg_vld = 1;
        msg_data = d;
        msg_bytes = b;
        msg_last = l;
        @(negedge clk);
        while (!msg_rdy) begin
            t++;
            if (t > 5000) begin
                $display("FAIL msg_accept: msg_rdy stayed 0 for 5000 cycles, required 1");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        msg_vld = 0;
        msg_last = 0;
        if (gap_en && $urandom_range(3) == 0)
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
    endtask

    task automatic send_msg(input bq_t m, input bit ztail);
        int sz = m.size();
        int nb;
        bit zt = ztail && sz % 4 == 0 && sz > 0;
        logic [31:0] w;
        model(m);
        if (sz == 0) begin
            drive_word($urandom, 3'd0, 1'b1);
            return;
        end
        for (int i = 0; i < sz; i += 4) begin
            nb = (sz - i < 4) ? sz - i : 4;
            w = $urandom;
            for (int j = 0; j < nb; j++) w[31-8*j -: 8] = m[i+j];
            drive_word(w, 3'(nb), (i + 4 >= sz) && !zt);
        end
        if (zt) drive_word($urandom, 3'd0, 1'b1);
    endtask

    function automatic bq_t mk(input int len, input logic [7:0] v, input bit rnd);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(rnd ? 8'($urandom) : v);
        return q;
    endfunction

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d chunks outstanding, required 0", expq.size());
            expq.delete();
        end
    endtask

    // every handshake is compared with the model; stalled chunks must hold still
    always @(negedge clk) begin
        if (rst) prev_stall = 0;
        else begin
            if (prev_stall) begin
                checks++;
                if (chunk_vld !== 1'b1 || chunk_data !== pd || chunk_last !== pl) begin
                    errors++;
                    $display("FAIL hold: vld=%b last=%b data=%h required vld=1 last=%b data=%h",
                             chunk_vld, chunk_last, chunk_data, pl, pd);
                end
            end
            if (chunk_vld && chunk_rdy) begin
                mc.d = chunk_data;
                mc.l = chunk_last;
                got.push_back(mc);
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL chunk: got %h last=%b, required no chunk", mc.d, mc.l);
                end else begin
                    me = expq.pop_front();
                    if (mc.d !== me.d || mc.l !== me.l) begin
                        errors++;
                        $display("FAIL chunk: got %h last=%b, required %h last=%b", mc.d, mc.l, me.d, me.l);
                    end
                end
            end
`ifndef SHA256_PADDER_DBUF_EN
            if (chunk_vld) begin
                checks++;
                if (msg_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL msg_rdy_emit: got %b required 0", msg_rdy);
                end
            end
`endif
            prev_stall = chunk_vld && !chunk_rdy;
            pd = chunk_data;
            pl = chunk_last;
        end
    end

    initial begin
        rst = 1;
        msg_vld = 0;
        msg_data = 0;
        msg_bytes = 0;
        msg_last = 0;
        chunk_rdy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 512'(msg_rdy), 512'(0));
        rst = 0;
        @(negedge clk);
        chk("reset_vld", 512'(chunk_vld), 512'(0));
        chk("reset_last", 512'(chunk_last), 512'(0));
        chk("reset_data", chunk_data, 512'(0));
        chk("reset_rdy", 512'(msg_rdy), 512'(1));
        @(posedge clk);
        #1;
        // "abc" with latency and 5 cycles of backpressure
        got.delete();
        send_msg('{8'h61, 8'h62, 8'h63}, 0);
        @(negedge clk);
        chk("lat_pad_vld", 512'(chunk_vld), 512'(0));
        @(negedge clk);
        chk("lat_emit_vld", 512'(chunk_vld), 512'(1));
        snap = chunk_data;
`ifdef SHA256_PADDER_DBUF_EN
        chk("bp_msg_rdy", 512'(msg_rdy), 512'(1));
`else
        chk("bp_msg_rdy", 512'(msg_rdy), 512'(0));
`endif
        repeat (5) @(negedge clk);
        chk("bp_data", chunk_data, snap);
        chk("bp_vld", 512'(chunk_vld), 512'(1));
        @(posedge clk);
        #1;
        chunk_rdy = 1;
        drain();
        lit = '0;
        lit[0] = 32'h61626380;
        lit[15] = 32'h00000018;
        chk("abc_count", 512'(got.size()), 512'(1));
        chk("abc_data", got[0].d, lit);
        chk("abc_last", 512'(got[0].l), 512'(1));
        // empty message
        got.delete();
        send_msg(mk(0, 8'h00, 0), 0);
        drain();
        lit = '0;
        lit[0] = 32'h80000000;
        chk("empty_data", got[0].d, lit);
        chk("empty_last", 512'(got[0].l), 512'(1));
        // 56 bytes: the length no longer fits
        got.delete();
        send_msg(mk(56, 8'h61, 0), 0);
        drain();
        lit = '0;
        for (int w = 0; w < 14; w++) lit[w] = 32'h61616161;
        lit[14] = 32'h80000000;
        chk("b56_a_data", got[0].d, lit);
        chk("b56_a_last", 512'(got[0].l), 512'(0));
        lit = '0;
        lit[15] = 32'h000001C0;
        chk("b56_b_data", got[1].d, lit);
        chk("b56_b_last", 512'(got[1].l), 512'(1));
        // 64 bytes: marker spills into the length chunk
        got.delete();
        send_msg(mk(64, 8'h61, 0), 0);
        drain();
        for (int w = 0; w < 16; w++) lit[w] = 32'h61616161;
        chk("b64_a_data", got[0].d, lit);
        chk("b64_a_last", 512'(got[0].l), 512'(0));
        lit = '0;
        lit[0] = 32'h80000000;
        lit[15] = 32'h00000200;
        chk("b64_b_data", got[1].d, lit);
        chk("b64_b_last", 512'(got[1].l), 512'(1));
        // reset while a full chunk waits in EMIT
        chunk_rdy = 0;
        for (int i = 0; i < 16; i++) drive_word(32'h11111111 * (i + 1), 3'd4, 1'b0);
        chk("mid_emit_vld", 512'(chunk_vld), 512'(1));
        rst = 1;
        @(negedge clk);
        chk("mid_rst_rdy", 512'(msg_rdy), 512'(0));
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid_rst_vld", 512'(chunk_vld), 512'(0));
        chunk_rdy = 1;
        got.delete();
        send_msg('{8'h61, 8'h62, 8'h63}, 0);
        drain();
        lit = '0;
        lit[0] = 32'h61626380;
        lit[15] = 32'h00000018;
        chk("post_rst_abc", got[0].d, lit);
        chk("post_rst_count", 512'(got.size()), 512'(1));
        // random messages, gaps and backpressure
        rand_rdy = 1;
        gap_en = 1;
        for (int m = 0; m < 40; m++) begin
            int len;
            int pick[8] = '{52, 55, 56, 59, 60, 63, 64, 120};
            len = ($urandom_range(2) == 0) ? pick[$urandom_range(7)] : int'($urandom_range(0, 140));
            send_msg(mk(len, 8'h00, 1), $urandom_range(1) == 1);
        end
        drain();
        rand_rdy = 0;
        gap_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
